l2_mem_bridge: RTL and testbench
================================

// Module: l2_mem_bridge
// PURPOSE
//  Downstream of the L2 cache: accepts whole-line read/write requests on the L2 memory-side handshake.
//  Serialises each line into BEATS beats of BEAT_BITS on a burst memory bus (cmd / wdata / rdata channels).
//  Reassembles read beats into a line and returns it to L2 as a one-cycle response pulse.
//  One transaction in flight; no reordering, no buffering beyond one line.
// PARAMETERS
//  ADDR_WIDTH  pkg_opengpu::ADDR_WIDTH       byte address width
//  LINE_BITS   pkg_opengpu::CACHE_LINE_BITS  line width (512)
//  BEAT_BITS   pkg_opengpu::MEM_BEAT_BITS    bus beat width (64); LINE_BITS/BEAT_BITS power of 2, >=2
//  BEATS       LINE_BITS/BEAT_BITS           derived localparam; beat counter width $clog2(BEATS)
// PORTS
//  clk             in   1           single clock, all logic posedge
//  rst             in   1           asynchronous, active-high reset
//  l2_req_valid    in   1           L2 request present; held until accepted
//  l2_req_we       in   1           1 = line write(back), 0 = line fill read
//  l2_req_addr     in   ADDR_WIDTH  line address; offset bits ignored (forced 0)
//  l2_req_wdata    in   LINE_BITS   write line
//  l2_ready        out  1           accept strobe; request taken when valid && ready
//  l2_resp_valid   out  1           one-cycle pulse, read data valid (reads only)
//  l2_resp_rdata   out  LINE_BITS   assembled read line
//  mem_cmd_valid   out  1           burst command valid
//  mem_cmd_ready   in   1           command accepted
//  mem_cmd_we      out  1           burst direction
//  mem_cmd_addr    out  ADDR_WIDTH  line-aligned burst address
//  mem_cmd_len     out  8           BEATS-1
//  mem_wdata_valid out  1           write beat valid
//  mem_wdata_ready in   1           write beat accepted
//  mem_wdata       out  BEAT_BITS   write beat, beat 0 = line bits [BEAT_BITS-1:0]
//  mem_wdata_last  out  1           high on beat BEATS-1
//  mem_rdata_valid in   1           read beat valid
//  mem_rdata_ready out  1           read beat accept
//  mem_rdata       in   BEAT_BITS   read beat, same ordering as write
//  mem_rdata_last  in   1           memory marks final beat
//  proto_err       out  1           sticky: rdata_last mismatch vs beat count
//  stat_reads/stat_writes/stat_busy  out 32 each  counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, beat_cnt 0, all valid/ready outputs 0 (l2_ready forced 0 while rst high), rdata 0, proto_err 0.
//  Reset mid-transaction aborts silently; partial line discarded; memory side is reset by the same rst.
//  FSM IDLE -> CMD -> (WDATA | RDATA) ; RDATA -> RESP -> IDLE ; WDATA -> IDLE.
//  IDLE: l2_ready=1; on l2_req_valid latch we/addr(aligned)/wdata, beat_cnt=0 -> CMD next cycle.
//  CMD: mem_cmd_valid=1, fields from latches, held stable until mem_cmd_ready; then -> WDATA if we else RDATA.
//  WDATA: mem_wdata_valid=1, mem_wdata = line[beat_cnt*BEAT_BITS +: BEAT_BITS]; advance on ready;
//         handshake at beat_cnt==BEATS-1 -> IDLE (writes produce no l2 response).
//  RDATA: mem_rdata_ready=1; each valid beat stored at beat_cnt slot, cnt++; beat BEATS-1 -> RESP.
//         rdata_last at cnt!=BEATS-1, or absent at BEATS-1, sets proto_err; FSM still completes by count.
//  RESP: l2_resp_valid=1 exactly one cycle, rdata held until next read completes -> IDLE.
//  Min latency with zero-wait memory: read accept t0, cmd t1, beats t2..t1+BEATS, resp t2+BEATS.
//  beat_cnt wraps to 0 after final beat; back-to-back requests accepted in IDLE only.
//  l2_ready low in all non-IDLE states, so an L2 write followed by fill stalls until write burst done.
// CONFIGURATION
//  MEM_BRIDGE_STATS_EN defined: stat_reads/stat_writes ++ on cmd handshake per direction;
//    stat_busy ++ every cycle state!=IDLE; all wrap at 2^32, reset to 0.
//  Undefined: counters not built, stat_* tied to 32'd0; ports always present.
// STRUCTURE
//  pkg_opengpu: add MEM_BEAT_BITS localparam and mem_bridge_state_t enum (IDLE,CMD,WDATA,RDATA,RESP).
//  Flat module; no sub-module warranted (gearbox is an indexed part-select plus counter).
// TESTING
//  Read, zero-wait mem, addr 0x0000_1234 -> cmd addr 0x0000_1200 len 7 we 0; 8 beats 0x11..0x88 -> resp line {0x88..0x11}, pulse 1 cycle at t10.
//  Write line = beat i value i+1, wdata_ready toggling 1/0 -> 8 beats in order, last only on beat 7, no l2_resp_valid.
//  mem_cmd_ready held low 5 cycles -> cmd fields stable, l2_ready low throughout, no beats issued.
//  rdata_last on beat 3 -> proto_err=1 sticky, response still after beat 7; cleared only by rst.
//  rst asserted during RDATA beat 4 -> all outputs 0 next edge, IDLE, next read completes normally.
//  MEM_BRIDGE_STATS_EN: 2 reads + 1 write zero-wait -> stat_reads=2, stat_writes=1; macro off -> all 0.

Source files
------------

// File: rtl/pkg_opengpu.sv
`default_nettype none
// ============================================================================
// Module   : pkg_opengpu
// Purpose  : Shared widths and the memory-bridge state encoding.
// Revision : 1.0
// ============================================================================
package pkg_opengpu;

    localparam int ADDR_WIDTH      = 32;
    localparam int CACHE_LINE_BITS = 512;
    localparam int MEM_BEAT_BITS   = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        RESP  = 3'd4
    } mem_bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_bridge
// Purpose  : Serialises L2 line requests into beat bursts and reassembles
//            read beats into a line. MEM_BRIDGE_STATS_EN builds the counters.
// Revision : 1.0
// ============================================================================
module l2_mem_bridge #(
    parameter int ADDR_WIDTH = pkg_opengpu::ADDR_WIDTH,
    parameter int LINE_BITS  = pkg_opengpu::CACHE_LINE_BITS,
    parameter int BEAT_BITS  = pkg_opengpu::MEM_BEAT_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_req_valid,
    input  logic                  l2_req_we,
    input  logic [ADDR_WIDTH-1:0] l2_req_addr,
    input  logic [LINE_BITS-1:0]  l2_req_wdata,
    output logic                  l2_ready,
    output logic                  l2_resp_valid,
    output logic [LINE_BITS-1:0]  l2_resp_rdata,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [7:0]            mem_cmd_len,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [BEAT_BITS-1:0]  mem_wdata,
    output logic                  mem_wdata_last,
    input  logic                  mem_rdata_valid,
    output logic                  mem_rdata_ready,
    input  logic [BEAT_BITS-1:0]  mem_rdata,
    input  logic                  mem_rdata_last,
    output logic                  proto_err,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes,
    output logic [31:0]           stat_busy
);
    import pkg_opengpu::*;

    localparam int BEATS   = LINE_BITS / BEAT_BITS;
    localparam int c_CNT_W = $clog2(BEATS);
    localparam int c_OFF_W = $clog2(LINE_BITS / 8);

    localparam logic [c_CNT_W-1:0]    c_LAST     = c_CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'((64'd1 << c_OFF_W) - 64'd1);

    mem_bridge_state_t     r_state;
    logic                  r_l2_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_BITS-1:0]  r_wline;
    logic [LINE_BITS-1:0]  r_rline;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_cmd_valid;
    logic                  r_wdata_valid;
    logic                  r_rdata_ready;
    logic                  r_resp_valid;
    logic                  r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_l2_ready    <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wline       <= '0;
            r_rline       <= '0;
            r_cnt         <= '0;
            r_cmd_valid   <= 1'b0;
            r_wdata_valid <= 1'b0;
            r_rdata_ready <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (l2_req_valid) begin
                        r_we        <= l2_req_we;
                        r_addr      <= l2_req_addr & ~c_OFF_MASK;
                        r_wline     <= l2_req_wdata;
                        r_cnt       <= '0;
                        r_l2_ready  <= 1'b0;
                        r_cmd_valid <= 1'b1;
                        r_state     <= CMD;
                    end
                end
                CMD: begin
                    if (mem_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (r_we) begin
                            r_wdata_valid <= 1'b1;
                            r_state       <= WDATA;
                        end else begin
                            r_rdata_ready <= 1'b1;
                            r_state       <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (mem_wdata_ready) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_wdata_valid <= 1'b0;
                            r_l2_ready    <= 1'b1;
                            r_state       <= IDLE;
                        end
                    end
                end
                RDATA: begin
                    if (mem_rdata_valid) begin
                        r_rline[r_cnt*BEAT_BITS +: BEAT_BITS] <= mem_rdata;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        // Memory's last marker is advisory; completion is decided by the count.
                        if (mem_rdata_last != (r_cnt == c_LAST)) begin
                            r_proto_err <= 1'b1;
                        end
                        if (r_cnt == c_LAST) begin
                            r_rdata_ready <= 1'b0;
                            r_resp_valid  <= 1'b1;
                            r_state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    r_l2_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_l2_ready <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign l2_ready        = r_l2_ready & ~rst;
    assign l2_resp_valid   = r_resp_valid;
    assign l2_resp_rdata   = r_rline;
    assign mem_cmd_valid   = r_cmd_valid;
    assign mem_cmd_we      = r_we;
    assign mem_cmd_addr    = r_addr;
    assign mem_cmd_len     = 8'(BEATS - 1);
    assign mem_wdata_valid = r_wdata_valid;
    assign mem_wdata       = r_wline[r_cnt*BEAT_BITS +: BEAT_BITS];
    assign mem_wdata_last  = r_wdata_valid & (r_cnt == c_LAST);
    assign mem_rdata_ready = r_rdata_ready;
    assign proto_err       = r_proto_err;

`ifdef MEM_BRIDGE_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_busy   <= '0;
        end else begin
            if (r_cmd_valid && mem_cmd_ready) begin
                if (r_we) begin
                    r_stat_writes <= r_stat_writes + 32'd1;
                end else begin
                    r_stat_reads <= r_stat_reads + 32'd1;
                end
            end
            if (r_state != IDLE) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_busy   = r_stat_busy;
`else
    assign stat_reads  = 32'd0;
    assign stat_writes = 32'd0;
    assign stat_busy   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_bridge
// Purpose  : Directed scoreboard bench for l2_mem_bridge.
// Revision : 1.0
// ============================================================================
module tb_l2_mem_bridge;
    import pkg_opengpu::*;

    localparam int AW    = ADDR_WIDTH;
    localparam int LB    = CACHE_LINE_BITS;
    localparam int BB    = MEM_BEAT_BITS;
    localparam int BEATS = LB / BB;

    logic          clk = 1'b0;
    logic          rst;
    logic          l2_req_valid, l2_req_we;
    logic [AW-1:0] l2_req_addr;
    logic [LB-1:0] l2_req_wdata;
    logic          l2_ready, l2_resp_valid;
    logic [LB-1:0] l2_resp_rdata;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [7:0]    mem_cmd_len;
    logic          mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
    logic [BB-1:0] mem_wdata;
    logic          mem_rdata_valid, mem_rdata_ready, mem_rdata_last;
    logic [BB-1:0] mem_rdata;
    logic          proto_err;
    logic [31:0]   stat_reads, stat_writes, stat_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [LB-1:0] exp_q[$];
    logic [BB:0]   wexp_q[$];

    always #5 clk = ~clk;

    l2_mem_bridge dut (
        .clk(clk), .rst(rst),
        .l2_req_valid(l2_req_valid), .l2_req_we(l2_req_we),
        .l2_req_addr(l2_req_addr), .l2_req_wdata(l2_req_wdata),
        .l2_ready(l2_ready), .l2_resp_valid(l2_resp_valid), .l2_resp_rdata(l2_resp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
        .mem_rdata(mem_rdata), .mem_rdata_last(mem_rdata_last),
        .proto_err(proto_err),
        .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_busy(stat_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = AW'(LB / 8 - 1);
        return a & ~m;
    endfunction

    // Read transaction; abort_at >= 0 asserts rst while that beat is presented.
    task automatic do_read(input logic [AW-1:0] addr, input logic [LB-1:0] line,
                           input int cmd_wait, input int last_pos, input int abort_at);
        logic [LB-1:0] got;
        check("rd_req_ready", l2_ready, 1);
        l2_req_valid = 1'b1;
        l2_req_we    = 1'b0;
        l2_req_addr  = addr;
        l2_req_wdata = rand_line();
        exp_q.push_back(line);
        tick();
        l2_req_valid = 1'b0;
        check("rd_cmd_valid", mem_cmd_valid, 1);
        check("rd_cmd_we", mem_cmd_we, 0);
        check("rd_cmd_addr", mem_cmd_addr, align(addr));
        check("rd_cmd_len", mem_cmd_len, BEATS - 1);
        for (int w = 0; w < cmd_wait; w++) begin
            tick();
            check("stall_cmd_valid", mem_cmd_valid, 1);
            check("stall_cmd_addr", mem_cmd_addr, align(addr));
            check("stall_l2_ready", l2_ready, 0);
            check("stall_no_beats", {mem_rdata_ready, mem_wdata_valid}, 0);
        end
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        check("rd_cmd_dropped", mem_cmd_valid, 0);
        check("rd_rdata_ready", mem_rdata_ready, 1);
        for (int i = 0; i < BEATS; i++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = line[i*BB +: BB];
            mem_rdata_last  = (i == last_pos);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                check("abort_cmd_valid", mem_cmd_valid, 0);
                check("abort_rdata_ready", mem_rdata_ready, 0);
                check("abort_resp_valid", l2_resp_valid, 0);
                check("abort_l2_ready", l2_ready, 0);
                check("abort_proto_err", proto_err, 0);
                check("abort_rdata", l2_resp_rdata, 0);
                rst             = 1'b0;
                mem_rdata_valid = 1'b0;
                mem_rdata_last  = 1'b0;
                exp_q.delete();
                tick();
                check("abort_idle_ready", l2_ready, 1);
                return;
            end
            tick();
            if (i == last_pos && last_pos < BEATS - 1) check("proto_err_set", proto_err, 1);
        end
        mem_rdata_valid = 1'b0;
        mem_rdata_last  = 1'b0;
        check("rd_resp_valid", l2_resp_valid, 1);
        check("rd_resp_l2_ready", l2_ready, 0);
        got = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rd_resp_line", l2_resp_rdata, got);
        tick();
        check("rd_resp_pulse_end", l2_resp_valid, 0);
        check("rd_back_idle", l2_ready, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LB-1:0] line, input bit toggle);
        int n;
        int t;
        logic [BB:0] e;
        check("wr_req_ready", l2_ready, 1);
        l2_req_valid = 1'b1;
        l2_req_we    = 1'b1;
        l2_req_addr  = addr;
        l2_req_wdata = line;
        for (int i = 0; i < BEATS; i++) wexp_q.push_back({(i == BEATS - 1), line[i*BB +: BB]});
        tick();
        l2_req_valid = 1'b0;
        check("wr_cmd_valid", mem_cmd_valid, 1);
        check("wr_cmd_we", mem_cmd_we, 1);
        check("wr_cmd_addr", mem_cmd_addr, align(addr));
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        n = 0;
        t = 0;
        while (n < BEATS && t < 40) begin
            mem_wdata_ready = !toggle || (t % 2 == 0);
            if (l2_resp_valid) check("wr_no_resp", l2_resp_valid, 0);
            if (mem_wdata_valid && mem_wdata_ready) begin
                e = (wexp_q.size() > 0) ? wexp_q.pop_front() : '0;
                check("wr_beat_data", mem_wdata, e[BB-1:0]);
                check("wr_beat_last", mem_wdata_last, e[BB]);
                n++;
            end
            tick();
            t++;
        end
        mem_wdata_ready = 1'b0;
        wexp_q.delete();
        check("wr_beat_count", n, BEATS);
        check("wr_done_valid", mem_wdata_valid, 0);
        check("wr_done_resp", l2_resp_valid, 0);
        check("wr_done_ready", l2_ready, 1);
    endtask

    initial begin
        logic [LB-1:0] l1, lw;
        int er, ew, eb;
        rst = 1'b1;
        l2_req_valid = 1'b0; l2_req_we = 1'b0; l2_req_addr = '0; l2_req_wdata = '0;
        mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0;
        mem_rdata_valid = 1'b0; mem_rdata_last = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_l2_ready", l2_ready, 0);
        check("rst_valids", {mem_cmd_valid, mem_wdata_valid, mem_rdata_ready, l2_resp_valid}, 0);
        check("rst_rdata", l2_resp_rdata, 0);
        check("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", l2_ready, 1);

        for (int i = 0; i < BEATS; i++) begin
            l1[i*BB +: BB] = BB'((i + 1) * 'h11);
            lw[i*BB +: BB] = BB'(i + 1);
        end
        do_read(32'h0000_1234, l1, 0, BEATS - 1, -1);
        check("read1_no_proto", proto_err, 0);
        do_write(32'h0000_2040, lw, 1'b1);
        do_read(32'h0000_3000, rand_line(), 5, BEATS - 1, -1);
        do_read(32'h0000_4080, rand_line(), 0, 3, -1);
        check("proto_after_resp", proto_err, 1);
        do_read(32'h0000_5000, rand_line(), 0, BEATS - 1, -1);
        check("proto_sticky", proto_err, 1);
        do_read(32'h0000_6000, rand_line(), 0, BEATS - 1, 4);
        do_read(32'h0000_7010, rand_line(), 0, BEATS - 1, -1);
        do_write(32'h0000_8000, rand_line(), 1'b0);
        do_read(32'h0000_9000, rand_line(), 0, BEATS - 1, -1);

`ifdef MEM_BRIDGE_STATS_EN
        er = 2; ew = 1; eb = 2 * (BEATS + 2) + (BEATS + 1);
`else
        er = 0; ew = 0; eb = 0;
`endif
        check("stat_reads", stat_reads, er);
        check("stat_writes", stat_writes, ew);
        check("stat_busy", stat_busy, eb);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
